// File: rtl/serialadd_sched.sv
// Round-robin scheduler for a shared bit-serial 4-operand adder tree.
// Issues the load, carry-clear and capture strobes and hands the result back through a valid/ready handshake.
module serialadd_sched #(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [SW-1:0]    sel,
    output logic             ld,
    output logic [DEPTH-1:0] clr,
    output logic             cap,
    output logic             busy,
    output logic [N-1:0]     rsp_valid,
    input  logic [N-1:0]     rsp_ready
);

    localparam int CAPV = W + DEPTH + 1;
    localparam int CW   = $clog2(CAPV + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [SW-1:0]   ptr_reg;

    logic [CW-1:0]    cnt_plus;
    logic [DEPTH-1:0] clr_dec;
    logic             cap_dec;
    logic [SW-1:0]    win_idx;
    logic             win_any;
    logic [N-1:0]     win_onehot;
    logic [N-1:0]     sel_onehot;

    // cnt_reg is zero on entry to LOAD, so cnt_plus is the frame offset of the next cycle.
    assign cnt_plus = cnt_reg + 1'b1;
    assign cap_dec  = (cnt_plus == CW'(CAPV));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_clr
            assign clr_dec[gi] = (cnt_plus == CW'(gi + 1));
        end
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == SW'(gi));
            assign sel_onehot[gi] = (sel == SW'(gi));
        end
    endgenerate

    // First requester at or after ptr+1, wrapping; the last winner has lowest priority.
    always_comb begin
        int idx;
        win_idx = '0;
        win_any = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr_reg) + i) % N;
            if (!win_any && req[idx]) begin
                win_any = 1'b1;
                win_idx = SW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ptr_reg   <= SW'(N - 1);
            sel       <= '0;
            gnt       <= '0;
            ld        <= 1'b0;
            clr       <= '0;
            cap       <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= '0;
        end else begin
            ld  <= 1'b0;
            gnt <= '0;
            clr <= '0;
            cap <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (win_any) begin
                        state_reg <= LOAD;
                        sel       <= win_idx;
                        ptr_reg   <= win_idx;
                        ld        <= 1'b1;
                        gnt       <= win_onehot;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    state_reg <= RUN;
                    cnt_reg   <= cnt_plus;
                    clr       <= clr_dec;
                    cap       <= cap_dec;
                end
                RUN: begin
                    if (cnt_reg == CW'(CAPV)) begin
                        state_reg <= RESP;
                        cnt_reg   <= '0;
                        rsp_valid <= sel_onehot;
                    end else begin
                        cnt_reg <= cnt_plus;
                        clr     <= clr_dec;
                        cap     <= cap_dec;
                    end
                end
                RESP: begin
                    if (|(rsp_ready & sel_onehot)) begin
                        rsp_valid <= '0;
                        // Re-arbitrate on the handshake so back-to-back frames have no bubble.
                        if (win_any) begin
                            state_reg <= LOAD;
                            sel       <= win_idx;
                            ptr_reg   <= win_idx;
                            ld        <= 1'b1;
                            gnt       <= win_onehot;
                        end else begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serialadd_sched.sv
// Directed bench for serialadd_sched with a behavioural bit-serial 4-operand adder tree (N=2, W=8, DEPTH=2).
module tb_serialadd_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [0:0] sel;
    logic       ld;
    logic [1:0] clr;
    logic       cap;
    logic       busy;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int prev_load  = 0;
    bit have_prev  = 0;

    serialadd_sched #(.N(2), .W(8), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .ld        (ld),
        .clr       (clr),
        .cap       (cap),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath: operand loaders, two-level serial adder tree, serial-to-parallel capture.
    logic [7:0] opa [2];
    logic [7:0] opb [2];
    logic [7:0] opc [2];
    logic [7:0] opd [2];
    logic [7:0] sa = '0, sb = '0, sc = '0, sd = '0;
    logic       s0ab = 1'b0, c0ab = 1'b0, s0cd = 1'b0, c0cd = 1'b0;
    logic       s1 = 1'b0, c1 = 1'b0;
    logic [7:0] sh = '0;
    logic [7:0] q  = '0;

    always @(posedge clk) begin
        logic ci_ab, ci_cd, ci_1;
        ci_ab = clr[0] ? 1'b0 : c0ab;
        ci_cd = clr[0] ? 1'b0 : c0cd;
        ci_1  = clr[1] ? 1'b0 : c1;
        if (ld) begin
            sa <= opa[sel];
            sb <= opb[sel];
            sc <= opc[sel];
            sd <= opd[sel];
        end else begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            sc <= sc >> 1;
            sd <= sd >> 1;
        end
        s0ab <= sa[0] ^ sb[0] ^ ci_ab;
        c0ab <= (sa[0] & sb[0]) | (sa[0] & ci_ab) | (sb[0] & ci_ab);
        s0cd <= sc[0] ^ sd[0] ^ ci_cd;
        c0cd <= (sc[0] & sd[0]) | (sc[0] & ci_cd) | (sd[0] & ci_cd);
        s1   <= s0ab ^ s0cd ^ ci_1;
        c1   <= (s0ab & s0cd) | (s0ab & ci_1) | (s0cd & ci_1);
        sh   <= {s1, sh[7:1]};
        if (cap) q <= sh;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the LOAD cycle; returns in the first RESP cycle.
    task automatic frame(input int who, input logic [7:0] expq);
        logic [1:0] oh;
        logic [1:0] ce;
        oh = (who == 0) ? 2'b01 : 2'b10;
        check("load_strobes", {ld, cap, clr, gnt, rsp_valid}, {1'b1, 1'b0, 2'b00, oh, 2'b00});
        check("load_sel", 32'(sel), who);
        check("load_busy", 32'(busy), 1);
        if (have_prev) check("period", cyc - prev_load, 13);
        prev_load = cyc;
        have_prev = 1;
        for (int off = 1; off <= 11; off++) begin
            tick();
            ce = (off == 1) ? 2'b01 : ((off == 2) ? 2'b10 : 2'b00);
            check($sformatf("run_strobes_off%0d", off), {ld, cap, clr, gnt, rsp_valid},
                  {1'b0, (off == 11), ce, 2'b00, 2'b00});
        end
        tick();
        check("resp_valid", {ld, cap, clr, gnt, rsp_valid}, {1'b0, 1'b0, 2'b00, 2'b00, oh});
        check("resp_q", q, expq);
        check("resp_sel", 32'(sel), who);
    endtask

    initial begin
        opa[0] = 8'd10;  opb[0] = 8'd20;  opc[0] = 8'd30; opd[0] = 8'd40;
        opa[1] = 8'd200; opb[1] = 8'd100; opc[1] = 8'd50; opd[1] = 8'd7;

        // Reset held with requests pending
        rst = 1'b0; req = 2'b11; rsp_ready = 2'b11;
        tick(); tick();
        check("reset_outputs", {busy, sel, ld, cap, clr, gnt, rsp_valid}, 10'd0);

        // Idle with no requests
        rst = 1'b1; req = 2'b00; rsp_ready = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_quiet", {busy, ld, cap, clr, gnt, rsp_valid}, 9'd0);
        end

        // Single operation for requester 0; req dropped after grant
        req = 2'b01;
        tick();
        req = 2'b00;
        frame(0, 8'd100);
        rsp_ready = 2'b01;
        tick();
        check("single_idle", {busy, ld, cap, clr, gnt, rsp_valid}, 9'd0);
        rsp_ready = 2'b00;

        // Fairness with back-to-back frames from a fresh pointer
        rst = 1'b0;
        tick();
        rst = 1'b1; req = 2'b11; rsp_ready = 2'b11; have_prev = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            frame(i % 2, (i % 2) ? 8'd101 : 8'd100);
            if (i == 3) req = 2'b00;
            tick();
        end
        check("fair_idle", {busy, ld, gnt, rsp_valid}, 6'd0);
        rsp_ready = 2'b00;

        // Backpressure: response held, pending request waits, foreign ready ignored
        req = 2'b01; have_prev = 0;
        tick();
        req = 2'b10;
        frame(0, 8'd100);
        for (int k = 0; k < 5; k++) begin
            rsp_ready = (k < 3) ? 2'b00 : 2'b10;
            tick();
            check("bp_hold", {busy, ld, cap, clr, gnt, rsp_valid}, {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01});
            check("bp_q", q, 8'd100);
        end
        rsp_ready = 2'b01;
        tick();
        req = 2'b00; rsp_ready = 2'b00; have_prev = 0;
        frame(1, 8'd101);
        rsp_ready = 2'b10;
        tick();
        check("bp_idle", {busy, ld, gnt, rsp_valid}, 6'd0);
        rsp_ready = 2'b00;

        // Reset in the middle of a frame for requester 0
        req = 2'b01;
        tick();
        req = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        #1;
        check("midreset_outputs", {busy, sel, ld, cap, clr, gnt, rsp_valid}, 10'd0);
        tick();
        check("midreset_held", {busy, sel, ld, cap, clr, gnt, rsp_valid}, 10'd0);
        rst = 1'b1; req = 2'b11; have_prev = 0;
        tick();
        req = 2'b00;
        frame(0, 8'd100);
        rsp_ready = 2'b01;
        tick();
        check("final_idle", {busy, ld, cap, clr, gnt, rsp_valid}, 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serialadd_sched.md
Name: serialadd_sched

Overview:
- Scheduler and arbiter that shares one bit-serial 4-operand adder tree among N requesters.
- Datapath: parallel-to-serial loaders, DEPTH levels of serial adders, serial-to-parallel capture.
- Grants one requester at a time with round-robin fairness and drives the operand select.
- Generates the load, per-stage carry-clear and capture strobes that the ring counter previously produced.
- Returns completion to the granted requester through a valid/ready handshake.

Parameters:
- N, 2, number of requesters (2..8).
- W, 8, operand/result width in bits = serial frame length.
- DEPTH, 2, adder-tree levels between the loaders and the capture register.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req  in  N  per-requester operation request; level, held until granted.
- gnt  out  N  one-hot grant; pulses for exactly the LOAD cycle.
- sel  out  max(1,clog2(N))  operand-mux select = granted index; stable LOAD through end of RESP.
- ld  out  1  parallel load strobe to all loaders.
- clr  out  DEPTH  clr[k] clears the carry of adder level k at LSB arrival.
- cap  out  1  capture strobe to the serial-to-parallel register.
- busy  out  1  high in every state except IDLE.
- rsp_valid  out  N  one-hot completion to the granted requester; the result is on the datapath q.
- rsp_ready  in  N  completion accept, per requester.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, rr pointer=N-1 so requester 0 wins first, sel=0, and every output = 0. This applies immediately, including mid-operation. An in-flight operation is discarded and no rsp_valid is issued for it.
- States: IDLE, LOAD, RUN, RESP. All outputs are registered or decoded from state/cnt only, with no combinational path from req/rsp_ready to outputs.
- IDLE:
  - If req!=0, pick the first set bit searching from (ptr+1) mod N upward with wrap.
  - Register sel and ptr <= winner, then go to LOAD.
- LOAD (offset 0, 1 cycle): ld=1, gnt[sel]=1, cnt<=1, then go to RUN.
- RUN: cnt increments each cycle.
  - clr[k]=1 exactly when cnt==k+1, for k=0..DEPTH-1.
  - cap=1 exactly when cnt==W+DEPTH+1; the next state is RESP.
  - Frame offsets from LOAD: clr[k] at +k+1, cap at +W+DEPTH+1.
- RESP (from offset W+DEPTH+2): rsp_valid[sel]=1, held until rsp_ready[sel]=1. rsp_ready on other indices is ignored.
  - On handshake with req!=0: arbitrate in the same cycle and go directly to LOAD (zero bubble).
  - On handshake with req==0: go to IDLE.
- Operation period with back-to-back requests: W+DEPTH+3 cycles (LOAD + W+DEPTH+1 RUN + 1 RESP).
- req changes after grant do not affect the current operation. A requester dropping req before the response still receives rsp_valid.
- The counter width is sized for W+DEPTH+1; the counter never wraps inside a frame.
- Only one of ld, cap, or any clr bit is active per cycle; the offsets are disjoint because DEPTH < W+DEPTH+1.
- The result q is stable from offset W+DEPTH+2 until the next cap. No new ld is issued while rsp_valid is unaccepted.

Test Plan:
- Reset/idle: hold rst=0 with req=11 -> every output 0. Release rst with req=00 for 20 cycles -> busy=0, no strobes.
- Single operation (N=2, W=8, DEPTH=2): req=01 sampled in cycle t -> gnt=01, ld=1 at t+1; clr[0] at t+2; clr[1] at t+3; cap at t+12; rsp_valid=01 from t+13. With rsp_ready=01 at t+13 -> IDLE at t+14, busy=0.
- End-to-end with the adder tree, a,b,c,d = 10,20,30,40 -> q=100 while rsp_valid. Operands 200,100,50,7 -> q=101 (mod 256).
- Fairness: req=11 held with rsp_ready=11 -> grants 01,10,01,10; each LOAD immediately follows the prior handshake; period 13 cycles.
- Backpressure: rsp_ready=00 for 5 cycles in RESP with req=10 pending -> rsp_valid held, no ld, gnt stays 00. Raise rsp_ready -> LOAD for requester 1 on the next cycle.
- Reset mid-frame: assert rst=0 at offset 5 of RUN -> all outputs 0 within the same cycle. After release with req=11 -> requester 0 granted first, frame restarts from offset 0 with no rsp_valid for the aborted operation.
